// File: rtl/keypad_debounce_decoder.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce_decoder
// Purpose  : Turns scanned 4x4 keypad rows into debounced press/release events.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_debounce_decoder #(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   input  logic [1:0] col_idx,
   input  logic       col_adv,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic       key_release
);

   localparam logic [3:0] c_target = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   logic [3:0]  r_sync [SYNC_STAGES];
   logic [15:0] r_snap;
   logic        r_aligned;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_cand;
   logic        r_key_valid;
   logic [3:0]  r_key_code;
   logic        r_key_held;
   logic        r_key_release;

   logic [3:0]  w_pressed;
   logic [15:0] w_frame;
   logic [4:0]  w_ones;
   logic [3:0]  w_idx;
   logic        w_none;
   logic        w_single;
   logic        w_frame_done;
   logic [3:0]  w_cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 4'hF;
      end else begin
         r_sync[0] <= row_n;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_pressed = ~r_sync[SYNC_STAGES-1];

   // w_frame is the snapshot including the column being sampled this cycle,
   // so a completing frame is classified without an extra cycle of latency.
   always_comb begin
      w_frame = r_snap;
      if (col_adv) begin
         for (int r = 0; r < 4; r++) w_frame[{2'(r), col_idx}] = w_pressed[r];
      end
      w_ones = 5'd0;
      w_idx  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_frame[i]) begin
            w_ones = w_ones + 5'd1;
            w_idx  = 4'(i);
         end
      end
   end

   assign w_none       = (w_ones == 5'd0);
   assign w_single     = (w_ones == 5'd1);
   assign w_frame_done = col_adv && (col_idx == 2'd3);
   assign w_cnt_inc    = r_cnt + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_snap <= 16'h0000;
      else if (col_adv) r_snap <= w_frame;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_aligned     <= 1'b0;
         r_cnt         <= 4'd0;
         r_cand        <= 4'd0;
         r_key_valid   <= 1'b0;
         r_key_code    <= 4'd0;
         r_key_held    <= 1'b0;
         r_key_release <= 1'b0;
      end else begin
         r_key_valid   <= 1'b0;
         r_key_release <= 1'b0;
         if (w_frame_done) begin
            if (!r_aligned) begin
               // First sweep after reset may be partial; only lock on to it.
               r_aligned <= 1'b1;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (w_single) begin
                        r_cand <= w_idx;
                        if (c_target == 4'd1) begin
                           r_key_valid <= 1'b1;
                           r_key_code  <= w_idx;
                           r_key_held  <= 1'b1;
                           r_cnt       <= 4'd0;
                           r_state     <= ST_HELD;
                        end else begin
                           r_cnt   <= 4'd1;
                           r_state <= ST_PRESS_WAIT;
                        end
                     end
                  end
                  ST_PRESS_WAIT: begin
                     if (w_single && (w_idx == r_cand)) begin
                        if (w_cnt_inc == c_target) begin
                           r_key_valid <= 1'b1;
                           r_key_code  <= r_cand;
                           r_key_held  <= 1'b1;
                           r_cnt       <= 4'd0;
                           r_state     <= ST_HELD;
                        end else begin
                           r_cnt <= w_cnt_inc;
                        end
                     end else if (w_single) begin
                        r_cand <= w_idx;
                        r_cnt  <= 4'd1;
                     end else begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                     end
                  end
                  ST_HELD: begin
                     // No rollover: any non-empty frame keeps the current key held.
                     if (w_none) begin
                        if (c_target == 4'd1) begin
                           r_key_release <= 1'b1;
                           r_key_held    <= 1'b0;
                           r_cnt         <= 4'd0;
                           r_state       <= ST_IDLE;
                        end else begin
                           r_cnt   <= 4'd1;
                           r_state <= ST_RELEASE_WAIT;
                        end
                     end
                  end
                  ST_RELEASE_WAIT: begin
                     if (w_none) begin
                        if (w_cnt_inc == c_target) begin
                           r_key_release <= 1'b1;
                           r_key_held    <= 1'b0;
                           r_cnt         <= 4'd0;
                           r_state       <= ST_IDLE;
                        end else begin
                           r_cnt <= w_cnt_inc;
                        end
                     end else begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_HELD;
                     end
                  end
                  default: begin
                     r_cnt   <= 4'd0;
                     r_state <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign key_valid   = r_key_valid;
   assign key_code    = r_key_code;
   assign key_held    = r_key_held;
   assign key_release = r_key_release;

endmodule
`default_nettype wire

// File: tb/tb_keypad_debounce_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_debounce_decoder
// Purpose  : Scoreboard bench with a run-length key model for the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_debounce_decoder;

   localparam int DS = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_n;
   logic [1:0] col_idx;
   logic       col_adv;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;
   logic       key_release;

   always #5 clk = ~clk;

   keypad_debounce_decoder #(
      .DEBOUNCE_SCANS(DS),
      .SYNC_STAGES   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row_n      (row_n),
      .col_idx    (col_idx),
      .col_adv    (col_adv),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_held   (key_held),
      .key_release(key_release)
   );

   typedef struct {
      bit         is_rel;
      logic [3:0] code;
      int         due;
   } ev_t;

   ev_t exp_q[$];
   int total = 0;
   int bad   = 0;
   int pos_cnt = -1;
   int drv = 0;

   logic [15:0] keys = 16'h0000;
   bit          rst_req = 1'b0;
   int          sc_phase = 0;
   int          sc_col = 0;
   bit          frame_mark = 1'b0;

   logic [3:0]  prev_row1 = 4'hF, prev_row2 = 4'hF;
   bit          prev_rst1 = 1'b0, prev_rst2 = 1'b0;
   logic [15:0] m_snap;
   bit          m_aligned, m_held;
   int          run_kind, run_len;

   int          n_valid = 0, n_rel = 0;
   bit          mon_held = 1'b0;
   logic [3:0]  mon_code = 4'd0;

   always @(posedge clk) pos_cnt <= pos_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, pos_cnt);
      end
   endtask

   task automatic model_reset();
      m_snap    = 16'h0000;
      m_aligned = 1'b0;
      m_held    = 1'b0;
      run_kind  = -2;
      run_len   = 0;
      exp_q.delete();
   endtask

   // A press is a run of DS identical single-key sweeps while nothing is held;
   // a release is a run of DS empty sweeps while a key is held.
   task automatic model_frame();
      int  n;
      int  kind;
      ev_t e;
      n = $countones(m_snap);
      kind = 16;
      if (n == 0) kind = -1;
      else if (n == 1) begin
         for (int i = 0; i < 16; i++) if (m_snap[i]) kind = i;
      end
      if (kind == run_kind) run_len++;
      else begin
         run_kind = kind;
         run_len  = 1;
      end
      if (!m_held && kind >= 0 && kind < 16 && run_len == DS) begin
         e.is_rel = 1'b0; e.code = 4'(kind); e.due = drv;
         exp_q.push_back(e);
         m_held = 1'b1;
      end else if (m_held && kind == -1 && run_len == DS) begin
         e.is_rel = 1'b1; e.code = 4'd0; e.due = drv;
         exp_q.push_back(e);
         m_held = 1'b0;
      end
   endtask

   task automatic drive_now();
      logic [3:0] pr;
      rst_n   = rst_req;
      col_adv = (sc_phase == 7);
      col_idx = 2'(sc_col);
      for (int r = 0; r < 4; r++) row_n[r] = ~keys[r*4 + sc_col];
      frame_mark = col_adv && (sc_col == 3);
      if (!rst_n) model_reset();
      else if (col_adv) begin
         // Rows reach the sampler two clocks late; a reset in that window reads released.
         pr = (prev_rst1 && prev_rst2) ? ~prev_row2 : 4'b0000;
         for (int r = 0; r < 4; r++) m_snap[r*4 + sc_col] = pr[r];
         if (sc_col == 3) begin
            if (!m_aligned) begin
               m_aligned = 1'b1;
               run_kind  = -2;
               run_len   = 0;
            end else model_frame();
         end
      end
      prev_row2 = prev_row1; prev_rst2 = prev_rst1;
      prev_row1 = row_n;     prev_rst1 = rst_n;
      if (sc_phase == 7) begin
         sc_phase = 0;
         sc_col   = (sc_col + 1) % 4;
      end else sc_phase++;
   endtask

   task automatic step();
      @(negedge clk);
      drv++;
      drive_now();
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic run_frames(input int n);
      int c;
      c = 0;
      while (c < n) begin
         step();
         if (frame_mark) c++;
      end
   endtask

   always begin
      ev_t e;
      @(posedge clk);
      #2;
      if (!rst_n) begin
         chk("reset_outputs", {key_valid, key_held, key_release, key_code}, 32'd0);
         mon_held = 1'b0;
         mon_code = 4'd0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].due < pos_cnt) begin
            total++; bad++;
            $display("FAIL missing_event: got none expected %s code %0d due %0d now %0d",
                     exp_q[0].is_rel ? "release" : "press", exp_q[0].code, exp_q[0].due, pos_cnt);
            void'(exp_q.pop_front());
         end
         if (key_valid || key_release) begin
            if (key_valid) n_valid++;
            if (key_release) n_rel++;
            chk("valid_release_exclusive", key_valid & key_release, 32'd0);
            if (exp_q.size() == 0 || exp_q[0].due != pos_cnt) begin
               total++; bad++;
               $display("FAIL unexpected_pulse: got valid=%0b release=%0b code=%0d expected no pulse at %0d",
                        key_valid, key_release, key_code, pos_cnt);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", key_release, e.is_rel);
               if (!e.is_rel) begin
                  mon_code = e.code;
                  mon_held = 1'b1;
               end else mon_held = 1'b0;
            end
         end
         chk("key_held", key_held, mon_held);
         chk("key_code", key_code, mon_code);
      end
   end

   initial begin
      int v0, r0;
      model_reset();
      drive_now();

      // Reset, then idle sweeps
      run_cycles(5);
      rst_req = 1'b1;
      run_frames(10);
      chk("s1_no_valid", n_valid, 0);
      chk("s1_no_release", n_rel, 0);

      // Stable R1C1
      v0 = n_valid; r0 = n_rel;
      keys = 16'h0001;
      run_frames(6);
      chk("s2_one_valid", n_valid - v0, 1);
      chk("s2_code", key_code, 0);
      chk("s2_held", key_held, 1);
      keys = 16'h0000;
      run_frames(6);
      chk("s2_release", n_rel - r0, 1);

      // Bouncing R4C4
      v0 = n_valid; r0 = n_rel;
      for (int c = 0; c < 64; c++) begin
         if (c % 5 == 0) keys[15] = ~keys[15];
         step();
      end
      keys = 16'h8000;
      run_frames(6);
      chk("s3_one_valid", n_valid - v0, 1);
      chk("s3_code", key_code, 15);
      keys = 16'h0000;
      run_frames(6);
      chk("s3_release", n_rel - r0, 1);

      // Ghosting R1C1+R1C2, then R1C1 alone
      v0 = n_valid;
      keys = 16'h0003;
      run_frames(8);
      chk("s4_ghost_no_valid", n_valid - v0, 0);
      chk("s4_ghost_not_held", key_held, 0);
      keys = 16'h0001;
      run_frames(6);
      chk("s4_valid", n_valid - v0, 1);
      chk("s4_code", key_code, 0);
      keys = 16'h0000;
      run_frames(6);

      // Release glitch on R2C2
      v0 = n_valid; r0 = n_rel;
      keys = 16'h0020;
      run_frames(6);
      chk("s5_code", key_code, 5);
      keys = 16'h0000;
      run_frames(2);
      keys = 16'h0020;
      run_frames(1);
      keys = 16'h0000;
      run_frames(3);
      chk("s5_no_early_release", n_rel - r0, 0);
      run_frames(3);
      chk("s5_one_release", n_rel - r0, 1);
      chk("s5_one_valid", n_valid - v0, 1);
      chk("s5_not_held", key_held, 0);

      // Reset in the middle of debouncing R3C1
      v0 = n_valid;
      keys = 16'h0100;
      run_frames(3);
      run_cycles(3);
      rst_req = 1'b0;
      run_cycles(3);
      rst_req = 1'b1;
      run_frames(4);
      chk("s6_no_valid_early", n_valid - v0, 0);
      run_frames(3);
      chk("s6_one_valid", n_valid - v0, 1);
      chk("s6_code", key_code, 8);
      keys = 16'h0000;
      run_frames(6);

      // Random key patterns changing at arbitrary points in the sweep
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: keys = 16'h0000;
            1, 2: begin
               keys = 16'h0000;
               keys[$urandom_range(0, 15)] = 1'b1;
            end
            default: begin
               keys = 16'h0000;
               keys[$urandom_range(0, 15)] = 1'b1;
               keys[$urandom_range(0, 15)] = 1'b1;
            end
         endcase
         run_cycles($urandom_range(8, 200));
      end
      keys = 16'h0000;
      run_frames(8);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_debounce_decoder.md
Name: keypad_debounce_decoder

Overview:
Consumes the column-scan timing and raw row lines of the 4x4 keypad scanner and turns them into clean key events. It synchronizes the rows, assembles one 16-bit key snapshot per full column sweep, and debounces over whole sweeps. It emits a one-cycle key_valid pulse with a 4-bit key code, a held flag and a release pulse. The LED and application logic downstream consume these events instead of the raw row/column pair.

Parameters:
DEBOUNCE_SCANS, 4, number of consecutive identical full sweeps required to accept a press or a release (legal range 1..15).
SYNC_STAGES, 2, flip-flop stages in the row input synchronizer (minimum 2).

Ports:
clk  input  1  system clock, 25 MHz.
rst_n  input  1  asynchronous, active-low reset.
row_n  input  4  raw keypad rows {R4,R3,R2,R1}; active low; asynchronous to clk.
col_idx  input  2  index of the column currently driven low by the scanner.
col_adv  input  1  one-cycle pulse on the last cycle of a column dwell; col_idx is still valid in that cycle.
key_valid  output  1  one-cycle pulse when a debounced press is accepted.
key_code  output  4  code of the last accepted key = row*4 + col (R1C1=0, R1C2=1, ..., R4C4=15).
key_held  output  1  high from key_valid until the release is accepted.
key_release  output  1  one-cycle pulse when a debounced release is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, synchronizer flops set to 1 (released), snapshot cleared, FSM IDLE, counter 0, aligned=0. A reset mid-operation produces no pulse.
- Synchronizer: row_n passes through SYNC_STAGES flops. pressed[r] = ~row_sync[r].
- Sampling: on each col_adv, write pressed[3:0] into snapshot bits {r*4 + col_idx}.
- Frame completion: a col_adv with col_idx==3 completes a frame. The first completion after reset only sets aligned=1 and is discarded, because that sweep may have been partial. Later completions are evaluated.
- Frame class: NONE (0 bits set), SINGLE(k) (exactly 1 bit k set), MULTI (2 or more bits, treated as ghosting).
- FSM, evaluated once per completed frame, with cnt at 4 bits:
  - IDLE: SINGLE(k) → cand=k, cnt=1, go to PRESS_WAIT. NONE and MULTI → stay in IDLE.
  - PRESS_WAIT: SINGLE(cand) → cnt+1. SINGLE(other) → cand=other, cnt=1. NONE or MULTI → IDLE, cnt=0.
  - Accept a press when cnt reaches DEBOUNCE_SCANS. This includes the IDLE→PRESS_WAIT frame when DEBOUNCE_SCANS=1. On accept: key_valid=1 for one cycle, key_code=cand, key_held=1, go to HELD.
  - HELD: NONE → cnt=1, go to RELEASE_WAIT; if DEBOUNCE_SCANS=1, release immediately. SINGLE(cand), SINGLE(other) and MULTI → stay in HELD. No rollover: a new key needs a full release first.
  - RELEASE_WAIT: NONE → cnt+1. Accept the release when cnt reaches DEBOUNCE_SCANS: key_release=1 for one cycle, key_held=0, go to IDLE. Any non-NONE frame → HELD, cnt=0, no pulse.
- Latency: key_valid and key_release are registered. They assert in the clock cycle after the col_adv that completes the deciding frame.
- key_code changes only together with key_valid and holds its value through HELD and IDLE until the next accept. key_valid and key_release never assert in the same cycle.
- col_adv arriving in consecutive cycles is legal; each pulse is sampled.

Test Plan:
Bench setup for all scenarios: scanner model with col_adv every 8 cycles, col_idx cycling 0..3, DEBOUNCE_SCANS=4.
1. Reset: hold rst_n=0 for 5 cycles, then release with no keys pressed for 10 frames -> key_valid, key_held, key_release and key_code stay 0.
2. Stable press: drive row_n[0]=0 only while col_idx==0 (R1C1), starting after alignment -> exactly one key_valid one cycle after the 4th completed frame, key_code=0, key_held=1 for as long as the key is held.
3. Bounce: R4C4 toggles every 5 cycles for 2 frames, then stays stable -> a single key_valid with key_code=15, four frames after the bouncing stops; never two pulses.
4. Ghosting: R1C1 and R1C2 pressed together for 8 frames -> no key_valid, key_held=0. Then release R1C2 -> key_valid with code 0 after 4 frames.
5. Release path: hold R2C2 until key_code=5. Release, inject one pressed frame after 2 NONE frames, then release for good -> no key_release after the glitch. key_release fires one cycle after the 4th consecutive NONE frame, and key_held drops in the same cycle.
6. Reset mid-debounce: R3C1 (code 8) held for 3 frames, pulse rst_n low between col_adv pulses, keep the key held -> no pulse during reset. The first sweep after reset is discarded, and key_valid with code 8 comes only after 4 further full frames.
